// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared sizes and FSM encoding for the reorder buffer
package reorder_buffer_pkg;
    localparam int ROB_AW = 4;
    localparam int ROB_DEPTH = 2 ** ROB_AW;
    localparam int XLEN = 32;
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} rob_state_e;
endpackage

// File: rtl/rob_entry_array.sv
// rob_entry_array: per-entry storage, CDB capture and combinational operand lookup
module rob_entry_array
    import reorder_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              alloc_we,
    input  logic [ROB_AW-1:0] alloc_pos,
    input  logic [4:0]        alloc_rd,
    input  logic              alloc_is_branch,
    input  logic              alloc_pred_taken,
    input  logic              commit_we,
    input  logic [ROB_AW-1:0] head_pos,
    input  logic              cdb_valid,
    input  logic [ROB_AW-1:0] cdb_pos,
    input  logic [XLEN-1:0]   cdb_val,
    input  logic              cdb_taken,
    input  logic [XLEN-1:0]   cdb_target,
    input  logic [ROB_AW-1:0] q1_pos,
    input  logic [ROB_AW-1:0] q2_pos,
    output logic              head_ready,
    output logic [4:0]        head_rd,
    output logic [XLEN-1:0]   head_val,
    output logic              head_mispredict,
    output logic [XLEN-1:0]   head_target,
    output logic              q1_ready,
    output logic [XLEN-1:0]   q1_val,
    output logic              q2_ready,
    output logic [XLEN-1:0]   q2_val
);
    logic [ROB_DEPTH-1:0] busy, ready, is_branch, pred_taken, taken;
    logic [4:0]           rd     [ROB_DEPTH];
    logic [XLEN-1:0]      val    [ROB_DEPTH];
    logic [XLEN-1:0]      target [ROB_DEPTH];
    logic                 cap, hit1, hit2;

    assign cap = rdy & cdb_valid & busy[cdb_pos];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy  <= '0;
            ready <= '0;
        end else if (flush) begin
            busy  <= '0;
            ready <= '0;
        end else begin
            if (commit_we) busy[head_pos] <= 1'b0;
            if (cap) ready[cdb_pos] <= 1'b1;
            if (alloc_we) begin
                busy[alloc_pos]  <= 1'b1;
                ready[alloc_pos] <= 1'b0;
            end
        end
    end

    // payload needs no reset: it is only read once busy/ready say it is valid
    always_ff @(posedge clk) begin
        if (alloc_we) begin
            rd[alloc_pos]         <= alloc_rd;
            is_branch[alloc_pos]  <= alloc_is_branch;
            pred_taken[alloc_pos] <= alloc_pred_taken;
        end
        if (cap) begin
            val[cdb_pos]    <= cdb_val;
            taken[cdb_pos]  <= cdb_taken;
            target[cdb_pos] <= cdb_target;
        end
    end

    assign head_ready      = ready[head_pos];
    assign head_rd         = rd[head_pos];
    assign head_val        = val[head_pos];
    assign head_target     = target[head_pos];
    assign head_mispredict = is_branch[head_pos] & (taken[head_pos] ^ pred_taken[head_pos]);

    assign hit1     = cdb_valid & (cdb_pos == q1_pos);
    assign hit2     = cdb_valid & (cdb_pos == q2_pos);
    assign q1_ready = ready[q1_pos] | hit1;
    assign q2_ready = ready[q2_pos] | hit2;
    assign q1_val   = ready[q1_pos] ? val[q1_pos] : hit1 ? cdb_val : '0;
    assign q2_val   = ready[q2_pos] ? val[q2_pos] : hit2 ? cdb_val : '0;
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry in-order retirement queue with CDB capture and
// mispredict flush, driving the register file rename/commit interface
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              alloc_valid,
    input  logic [4:0]        alloc_rd,
    input  logic              alloc_is_branch,
    input  logic              alloc_pred_taken,
    output logic              alloc_ready,
    output logic              update_valid,
    output logic [ROB_AW-1:0] update_ROB_pos,
    output logic [4:0]        update_rd,
    input  logic              cdb_valid,
    input  logic [ROB_AW-1:0] cdb_pos,
    input  logic [XLEN-1:0]   cdb_val,
    input  logic              cdb_taken,
    input  logic [XLEN-1:0]   cdb_target,
    input  logic [ROB_AW-1:0] q1_pos,
    input  logic [ROB_AW-1:0] q2_pos,
    output logic              q1_ready,
    output logic              q2_ready,
    output logic [XLEN-1:0]   q1_val,
    output logic [XLEN-1:0]   q2_val,
    output logic              commit_valid,
    output logic [ROB_AW-1:0] commit_ROB_pos,
    output logic [4:0]        commit_rd,
    output logic [XLEN-1:0]   commit_val,
    output logic              jump_wrong,
    output logic [XLEN-1:0]   jump_target,
    output logic              rob_empty
);
    rob_state_e        state;
    logic [ROB_AW-1:0] head, tail;
    logic [ROB_AW:0]   count;
    logic              head_ready, head_mispredict, do_commit, flush;
    logic [4:0]        head_rd;
    logic [XLEN-1:0]   head_val, head_target;

    // count[ROB_AW] is set only at 16: full blocks allocation even if head retires this cycle
    assign alloc_ready    = (state == RUN) & ~count[ROB_AW] & ~jump_wrong & rdy;
    assign update_valid   = alloc_valid & alloc_ready;
    assign update_ROB_pos = tail;
    assign update_rd      = alloc_rd;
    assign rob_empty      = (count == '0);
    assign do_commit      = (state == RUN) & rdy & ~rob_empty & head_ready;
    assign flush          = rdy & (state == FLUSH);

    rob_entry_array u_entries (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .alloc_we(update_valid), .alloc_pos(tail), .alloc_rd(alloc_rd),
        .alloc_is_branch(alloc_is_branch), .alloc_pred_taken(alloc_pred_taken),
        .commit_we(do_commit), .head_pos(head),
        .cdb_valid(cdb_valid), .cdb_pos(cdb_pos), .cdb_val(cdb_val),
        .cdb_taken(cdb_taken), .cdb_target(cdb_target),
        .q1_pos(q1_pos), .q2_pos(q2_pos),
        .head_ready(head_ready), .head_rd(head_rd), .head_val(head_val),
        .head_mispredict(head_mispredict), .head_target(head_target),
        .q1_ready(q1_ready), .q1_val(q1_val), .q2_ready(q2_ready), .q2_val(q2_val)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= RUN;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            commit_valid   <= 1'b0;
            commit_ROB_pos <= '0;
            commit_rd      <= '0;
            commit_val     <= '0;
            jump_wrong     <= 1'b0;
            jump_target    <= '0;
        end else if (rdy) begin
            if (state == FLUSH) begin
                head         <= '0;
                tail         <= '0;
                count        <= '0;
                commit_valid <= 1'b0;
                jump_wrong   <= 1'b1;
                state        <= RUN;
            end else begin
                jump_wrong   <= 1'b0;
                commit_valid <= do_commit;
                count        <= count + (ROB_AW+1)'(update_valid) - (ROB_AW+1)'(do_commit);
                if (update_valid) tail <= tail + ROB_AW'(1);
                if (do_commit) begin
                    head           <= head + ROB_AW'(1);
                    commit_ROB_pos <= head;
                    commit_rd      <= head_rd;
                    commit_val     <= head_val;
                end
                // the mispredicted entry still retires; the flush follows one edge later
                if (do_commit & head_mispredict) begin
                    state       <= FLUSH;
                    jump_target <= head_target;
                end
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: random and directed traffic against a queue-based model,
// with a commit monitor popping expectations from a scoreboard
module tb_reorder_buffer;
    logic        clk = 0, rst = 0, rdy = 1;
    logic        alloc_valid = 0, alloc_is_branch = 0, alloc_pred_taken = 0;
    logic [4:0]  alloc_rd = 0;
    logic        alloc_ready, update_valid;
    logic [3:0]  update_ROB_pos;
    logic [4:0]  update_rd;
    logic        cdb_valid = 0, cdb_taken = 0;
    logic [3:0]  cdb_pos = 0;
    logic [31:0] cdb_val = 0, cdb_target = 0;
    logic [3:0]  q1_pos = 0, q2_pos = 0;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_val, q2_val;
    logic        commit_valid;
    logic [3:0]  commit_ROB_pos;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic        jump_wrong, rob_empty;
    logic [31:0] jump_target;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_is_branch(alloc_is_branch),
        .alloc_pred_taken(alloc_pred_taken), .alloc_ready(alloc_ready),
        .update_valid(update_valid), .update_ROB_pos(update_ROB_pos), .update_rd(update_rd),
        .cdb_valid(cdb_valid), .cdb_pos(cdb_pos), .cdb_val(cdb_val),
        .cdb_taken(cdb_taken), .cdb_target(cdb_target),
        .q1_pos(q1_pos), .q2_pos(q2_pos), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_val(q1_val), .q2_val(q2_val),
        .commit_valid(commit_valid), .commit_ROB_pos(commit_ROB_pos),
        .commit_rd(commit_rd), .commit_val(commit_val),
        .jump_wrong(jump_wrong), .jump_target(jump_target), .rob_empty(rob_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pos;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    bit   [15:0] amask, pend, done, mbr, mpr, mtk, res_tk;
    logic [31:0] dval[16], mtg[16], res_val[16], res_tg[16];
    logic [3:0]  mtail;
    logic [31:0] jt;
    int          fl, tests, fails, jw;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void clear_model();
        exp_q.delete();
        amask = '0;
        pend  = '0;
        done  = '0;
        mtail = 0;
        fl    = 0;
    endfunction

    task automatic qchk(input string nm, input logic [3:0] p, input logic r_act, input logic [31:0] v_act);
        bit hit;
        hit = cdb_valid && cdb_pos == p;
        if (amask[p]) begin
            chk({nm, "_ready"}, r_act, done[p] || hit);
            chk({nm, "_val"}, v_act, done[p] ? dval[p] : hit ? cdb_val : 32'h0);
        end
    endtask

    // apply inputs for one cycle, check combinational outputs, advance the model
    task automatic drive(input bit av, input logic [4:0] rd, input bit br, input bit pr,
                         input logic [31:0] v, input bit tk, input logic [31:0] tg,
                         input bit cv, input logic [3:0] cp, input logic [31:0] cval,
                         input bit ctk, input logic [31:0] ctg, input bit r);
        bit ear, cap;
        alloc_valid = av; alloc_rd = rd; alloc_is_branch = br; alloc_pred_taken = pr;
        cdb_valid = cv; cdb_pos = cp; cdb_val = cval; cdb_taken = ctk; cdb_target = ctg; rdy = r;
        #1;
        ear = r && exp_q.size() < 16 && fl == 0;
        chk("alloc_ready", alloc_ready, ear);
        chk("update_valid", update_valid, av && ear);
        if (av && ear) begin
            chk("update_pos", update_ROB_pos, mtail);
            chk("update_rd", update_rd, rd);
        end
        qchk("q1", q1_pos, q1_ready, q1_val);
        qchk("q2", q2_pos, q2_ready, q2_val);
        chk("jump_wrong", jump_wrong, fl == 1);
        if (fl == 1) chk("jump_target", jump_target, jt);
        if (fl != 2) chk("rob_empty", rob_empty, exp_q.size() == 0);
        cap = cv && r && amask[cp];
        if (cap) begin
            done[cp] = 1; pend[cp] = 0; dval[cp] = cval; mtk[cp] = ctk; mtg[cp] = ctg;
        end
        if (av && ear) begin
            exp_q.push_back(exp_t'{mtail, rd, v});
            amask[mtail] = 1; pend[mtail] = 1; done[mtail] = 0;
            mbr[mtail] = br; mpr[mtail] = pr;
            res_val[mtail] = v; res_tk[mtail] = tk; res_tg[mtail] = tg;
            mtail++;
        end
        if (r && fl > 0) fl--;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic step(input bit av, input logic [4:0] rd, input bit br, input bit pr,
                        input logic [31:0] v, input bit tk, input logic [31:0] tg,
                        input bit cv, input logic [3:0] cp, input logic [31:0] cval,
                        input bit ctk, input logic [31:0] ctg, input bit r);
        drive(av, rd, br, pr, v, tk, tg, cv, cp, cval, ctk, ctg, r);
        tick();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic alloc(input logic [4:0] rd, input logic [31:0] v);
        step(1, rd, 0, 0, v, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic cdb(input logic [3:0] p, input logic [31:0] v, input bit tk, input logic [31:0] tg);
        step(0, 0, 0, 0, 0, 0, 0, 1, p, v, tk, tg, 1);
    endtask

    task automatic reset_checks();
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_commit_pos", commit_ROB_pos, 0);
        chk("rst_commit_rd", commit_rd, 0);
        chk("rst_commit_val", commit_val, 0);
        chk("rst_jump_wrong", jump_wrong, 0);
        chk("rst_jump_target", jump_target, 0);
        chk("rst_rob_empty", rob_empty, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3 rst = 0;
        #1 reset_checks();
        clear_model();
        tick();
        rst = 1; alloc_valid = 0; cdb_valid = 0; rdy = 1;
        #1 chk("rst_alloc_ready", alloc_ready, 1);
    endtask

    task automatic rand_phase(input int n);
        bit r, av, br, pr, tk, cv, ctk;
        logic [3:0] p;
        logic [31:0] cval, ctg;
        for (int i = 0; i < n; i++) begin
            r  = $urandom_range(0, 9) != 0;
            av = $urandom_range(0, 4) < 3;
            br = $urandom_range(0, 3) == 0;
            pr = 1'($urandom_range(0, 1));
            tk = (br && $urandom_range(0, 7) == 0) ? !pr : pr;
            p  = 4'($urandom);
            cv = 0; cval = 0; ctk = 0; ctg = 0;
            if (pend[p]) begin
                cv = 1; cval = res_val[p]; ctk = res_tk[p]; ctg = res_tg[p];
            end else if (!amask[p] && $urandom_range(0, 1) == 1) begin
                cv = 1; cval = $urandom; ctk = 1'($urandom_range(0, 1)); ctg = $urandom;
            end
            q1_pos = 4'($urandom);
            q2_pos = $urandom_range(0, 1) == 1 ? p : 4'($urandom);
            step(av, 5'($urandom), br, pr, $urandom, tk, $urandom, cv, p, cval, ctk, ctg, r);
        end
    endtask

    task automatic drain();
        bit ok, sent;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (exp_q.size() == 0 && fl == 0) ok = 1;
            else begin
                sent = 0;
                for (int k = 0; k < 16 && !sent; k++)
                    if (pend[k]) begin
                        cdb(4'(k), res_val[k], res_tk[k], res_tg[k]);
                        sent = 1;
                    end
                if (!sent) idle();
            end
        end
        chk("drain_done", ok, 1);
    endtask

    // scoreboard monitor: a commit is fresh only if the edge that produced it had rdy = 1
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst && rdy && commit_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL commit_unexpected: got pos %0d expected none", commit_ROB_pos);
            end else begin
                e = exp_q.pop_front();
                chk("commit_pos", commit_ROB_pos, e.pos);
                chk("commit_rd", commit_rd, e.rd);
                chk("commit_val", commit_val, e.val);
                amask[e.pos] = 0;
                if (mbr[e.pos] && mtk[e.pos] != mpr[e.pos]) begin
                    jt = mtg[e.pos];
                    clear_model();
                    fl = 2;
                end
            end
        end
    end

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        #1 reset_checks();
        rst = 1;
        #1 chk("init_alloc_ready", alloc_ready, 1);
        tick();
        rand_phase(300);
        do_reset();
        rand_phase(300);
        drain();

        do_reset();
        alloc(5, 32'h11);
        alloc(6, 32'h22);
        alloc(7, 32'h33);
        cdb(2, 32'h33, 0, 0);
        cdb(0, 32'h11, 0, 0);
        cdb(1, 32'h22, 0, 0);
        for (int k = 0; k < 3; k++) begin
            chk("ooo_pulse", commit_valid, 1);
            idle();
        end
        chk("ooo_done", commit_valid, 0);

        do_reset();
        for (int i = 0; i < 16; i++) alloc(5'(i + 1), $urandom);
        chk("full_alloc_ready", alloc_ready, 0);
        cdb(0, res_val[0], 0, 0);
        idle();
        drive(1, 5'd20, 0, 0, 32'h2020, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("wrap_pos", update_ROB_pos, 0);
        tick();
        drain();

        do_reset();
        for (int i = 0; i < 5; i++) alloc(5'(i + 1), i == 4 ? 32'hAB : 32'(i));
        q1_pos = 4;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 32'hAB, 0, 0, 1);
        chk("bypass_ready", q1_ready, 1);
        chk("bypass_val", q1_val, 32'hAB);
        tick();
        drain();

        do_reset();
        alloc(9, 32'h99);
        cdb(0, 32'h99, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 10, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("stall_update_valid", update_valid, 0);
            tick();
            chk("stall_commit", commit_valid, 0);
        end
        idle();
        chk("resume_commit", commit_valid, 1);
        idle();

        do_reset();
        alloc(2, 32'h20);
        alloc(3, 32'h30);
        alloc(4, 32'h40);
        step(1, 1, 1, 0, 32'h44, 1, 32'h1000, 0, 0, 0, 0, 0, 1);
        alloc(8, 32'h80);
        cdb(0, 32'h20, 0, 0);
        cdb(1, 32'h30, 0, 0);
        cdb(2, 32'h40, 0, 0);
        cdb(3, 32'h44, 1, 32'h1000);
        jw = 0;
        for (int k = 0; k < 6; k++) begin
            idle();
            if (fl != 0) chk("mp_alloc_ready", alloc_ready, 0);
            if (jump_wrong) begin
                jw++;
                chk("mp_target", jump_target, 32'h1000);
            end
        end
        chk("mp_pulses", jw, 1);
        chk("mp_empty", rob_empty, 1);

        rand_phase(400);
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
